branch_resolve_unit: RTL and testbench

Sits between the fetch-side branch stream and the bimodal predictor. Accepts branch prediction requests, queries the predictor combinationally, and remembers each in-flight prediction in a small FIFO. When the branch resolves, it writes the outcome back through the predictor's update port and flags mispredictions. It also keeps branch and misprediction counters for evaluating predictor accuracy.

---
 rtl/branch_resolve_unit.sv | 110 +++++++++++
 tb/tb_branch_resolve_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: fronts a bimodal predictor, tracks in-flight
// predictions in a small FIFO, writes back resolved outcomes, flags
// mispredictions and counts branches / mispredictions.
module branch_resolve_unit #(
    parameter int NUM_INFLIGHT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_val,
    output logic        o_req_rdy,
    input  logic [31:0] i_req_pc,
    output logic        o_resp_taken,
    input  logic        i_resolve_val,
    output logic        o_resolve_rdy,
    input  logic        i_resolve_taken,
    output logic [31:0] o_bp_pc,
    input  logic        i_bp_prediction,
    output logic        o_bp_update_en,
    output logic        o_bp_update_val,
    output logic        o_mispredict,
    output logic [31:0] o_mispredict_pc,
    output logic [31:0] o_num_branches,
    output logic [31:0] o_num_mispredicts
);

    localparam int PTR_W = $clog2(NUM_INFLIGHT);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [31:0]      r_pc_mem   [NUM_INFLIGHT];
    logic             r_pred_mem [NUM_INFLIGHT];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic        w_empty;
    logic        w_full;
    logic [31:0] w_head_pc;
    logic        w_head_pred;
    logic        w_req_fire;
    logic        w_resolve_fire;
    logic        w_mispred;

    // Handshakes and predictor port muxing; resolution owns the single PC port.
    always_comb begin
        w_empty        = (r_count == '0);
        w_full         = (r_count == CNT_FULL);
        w_head_pc      = r_pc_mem[r_head];
        w_head_pred    = r_pred_mem[r_head];
        o_resolve_rdy  = !i_reset && !w_empty;
        o_req_rdy      = !i_reset && !w_full && !(i_resolve_val && !w_empty);
        w_resolve_fire = i_resolve_val && o_resolve_rdy;
        w_req_fire     = i_req_val && o_req_rdy;
        w_mispred      = w_resolve_fire && (i_resolve_taken != w_head_pred);
        o_resp_taken   = i_bp_prediction;
        o_bp_pc         = i_req_pc;
        o_bp_update_en  = 1'b0;
        o_bp_update_val = 1'b0;
        if (w_resolve_fire) begin
            o_bp_pc         = w_head_pc;
            o_bp_update_en  = 1'b1;
            o_bp_update_val = i_resolve_taken;
        end
    end

    // FIFO storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge i_clk) begin
        if (w_req_fire) begin
            r_pc_mem[r_tail]   <= i_req_pc;
            r_pred_mem[r_tail] <= i_bp_prediction;
        end
    end

    // Pointers and occupancy; push and pop never coincide.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_req_fire) begin
            r_tail  <= r_tail + PTR_ONE;
            r_count <= r_count + CNT_ONE;
        end else if (w_resolve_fire) begin
            r_head  <= r_head + PTR_ONE;
            r_count <= r_count - CNT_ONE;
        end
    end

    // Registered mispredict pulse and wrapping accuracy counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_mispredict      <= 1'b0;
            o_mispredict_pc   <= '0;
            o_num_branches    <= '0;
            o_num_mispredicts <= '0;
        end else begin
            o_mispredict <= w_mispred;
            if (w_mispred) begin
                o_mispredict_pc   <= w_head_pc;
                o_num_mispredicts <= o_num_mispredicts + 32'd1;
            end
            if (w_resolve_fire) begin
                o_num_branches <= o_num_branches + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: a 2-bit bimodal predictor model drives
// bp_prediction; directed stimulus pushes hand-computed expectations into a
// scoreboard that a negedge monitor pops whenever the DUT fires or pulses.
module tb_branch_resolve_unit;

    localparam int K_REQ  = 0;
    localparam int K_RES  = 1;
    localparam int K_MISP = 2;

    typedef struct {
        int          kind;
        logic [31:0] pc;
        logic        bit_v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_val;
    logic        req_rdy;
    logic [31:0] req_pc;
    logic        resp_taken;
    logic        resolve_val;
    logic        resolve_rdy;
    logic        resolve_taken;
    logic [31:0] bp_pc;
    logic        bp_prediction;
    logic        bp_update_en;
    logic        bp_update_val;
    logic        mispredict;
    logic [31:0] mispredict_pc;
    logic [31:0] num_branches;
    logic [31:0] num_mispredicts;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    logic [1:0] bht [1024];

    branch_resolve_unit #(.NUM_INFLIGHT(4)) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_req_val         (req_val),
        .o_req_rdy         (req_rdy),
        .i_req_pc          (req_pc),
        .o_resp_taken      (resp_taken),
        .i_resolve_val     (resolve_val),
        .o_resolve_rdy     (resolve_rdy),
        .i_resolve_taken   (resolve_taken),
        .o_bp_pc           (bp_pc),
        .i_bp_prediction   (bp_prediction),
        .o_bp_update_en    (bp_update_en),
        .o_bp_update_val   (bp_update_val),
        .o_mispredict      (mispredict),
        .o_mispredict_pc   (mispredict_pc),
        .o_num_branches    (num_branches),
        .o_num_mispredicts (num_mispredicts)
    );

    always #5 clk = ~clk;

    // Bimodal predictor: 1024 two-bit counters indexed by pc[11:2], cold = weakly not-taken.
    initial begin
        for (int i = 0; i < 1024; i++) bht[i] = 2'd1;
    end
    assign bp_prediction = bht[bp_pc[11:2]][1];
    always @(posedge clk) begin
        if (bp_update_en) begin
            if (bp_update_val && bht[bp_pc[11:2]] != 2'd3)
                bht[bp_pc[11:2]] <= bht[bp_pc[11:2]] + 2'd1;
            else if (!bp_update_val && bht[bp_pc[11:2]] != 2'd0)
                bht[bp_pc[11:2]] <= bht[bp_pc[11:2]] - 2'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // Monitor: mispredict pulses belong to the previous cycle, so check them before fires.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (mispredict) begin
                if (sb.size() == 0 || sb[0].kind != K_MISP)
                    flag($sformatf("stray_mispredict pc=%h", mispredict_pc));
                else begin
                    e = sb.pop_front();
                    chk("mispredict_pc", mispredict_pc, e.pc);
                end
            end else if (sb.size() != 0 && sb[0].kind == K_MISP) begin
                e = sb.pop_front();
                flag($sformatf("missing_mispredict pc=%h", e.pc));
            end
            if (req_val && req_rdy) begin
                if (sb.size() == 0 || sb[0].kind != K_REQ)
                    flag($sformatf("unexpected_req_fire pc=%h", req_pc));
                else begin
                    e = sb.pop_front();
                    chk("req_pc_order", req_pc, e.pc);
                    chk("resp_taken", {31'd0, resp_taken}, {31'd0, e.bit_v});
                    chk("req_bp_pc", bp_pc, req_pc);
                    chk("req_no_update", {31'd0, bp_update_en}, 32'd0);
                end
            end
            if (resolve_val && resolve_rdy) begin
                if (sb.size() == 0 || sb[0].kind != K_RES)
                    flag($sformatf("unexpected_resolve_fire bp_pc=%h", bp_pc));
                else begin
                    e = sb.pop_front();
                    chk("upd_bp_pc", bp_pc, e.pc);
                    chk("upd_en", {31'd0, bp_update_en}, 32'd1);
                    chk("upd_val", {31'd0, bp_update_val}, {31'd0, e.bit_v});
                end
            end
        end
    end

    // Tasks start and end just after a posedge.
    task automatic do_req(input logic [31:0] pc, input logic exp_pred);
        bit ok = 0;
        sb.push_back('{K_REQ, pc, exp_pred});
        req_val = 1'b1;
        req_pc  = pc;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_rdy) begin ok = 1; break; end
        end
        if (!ok) flag("req_timeout");
        @(posedge clk); #1;
        req_val = 1'b0;
    endtask

    task automatic do_resolve(input logic taken, input logic [31:0] exp_pc, input logic exp_misp);
        bit ok = 0;
        sb.push_back('{K_RES, exp_pc, taken});
        if (exp_misp) sb.push_back('{K_MISP, exp_pc, 1'b1});
        resolve_val   = 1'b1;
        resolve_taken = taken;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (resolve_rdy) begin ok = 1; break; end
        end
        if (!ok) flag("resolve_timeout");
        @(posedge clk); #1;
        resolve_val = 1'b0;
    endtask

    task automatic check_counters(input string tag, input int br, input int mp);
        @(negedge clk);
        chk({tag, "_num_branches"}, num_branches, br);
        chk({tag, "_num_mispredicts"}, num_mispredicts, mp);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_val = 1'b0; req_pc = '0;
        resolve_val = 1'b0; resolve_taken = 1'b0;

        // Reset: readys low while held, clean state after release
        @(negedge clk);
        chk("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
        chk("rst_resolve_rdy", {31'd0, resolve_rdy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_num_branches", num_branches, 32'd0);
        chk("post_rst_num_mispredicts", num_mispredicts, 32'd0);
        chk("post_rst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("post_rst_update_en", {31'd0, bp_update_en}, 32'd0);
        chk("post_rst_resolve_rdy", {31'd0, resolve_rdy}, 32'd0);
        chk("post_rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        @(posedge clk); #1;

        // Single branch on a cold predictor
        do_req(32'h100, 1'b0);
        do_resolve(1'b1, 32'h100, 1'b1);
        @(negedge clk);
        chk("single_mispredict", {31'd0, mispredict}, 32'd1);
        chk("single_num_mispredicts", num_mispredicts, 32'd1);
        chk("single_num_branches", num_branches, 32'd1);
        @(posedge clk); #1;

        // Fill and drain
        for (int i = 0; i < 4; i++) do_req(32'(i * 4), 1'b0);
        req_val = 1'b1; req_pc = 32'h10;
        @(negedge clk);
        chk("full_req_rdy", {31'd0, req_rdy}, 32'd0);
        chk("full_resolve_rdy", {31'd0, resolve_rdy}, 32'd1);
        @(posedge clk); #1;
        req_val = 1'b0;
        do_resolve(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("drain_req_rdy_back", {31'd0, req_rdy}, 32'd1);
        @(posedge clk); #1;
        for (int i = 1; i < 4; i++) do_resolve(1'b0, 32'(i * 4), 1'b0);
        check_counters("fill", 5, 1);

        // Priority conflict: two resolves win, then the request goes
        do_req(32'h10, 1'b0);
        do_req(32'h14, 1'b0);
        sb.push_back('{K_RES, 32'h10, 1'b0});
        sb.push_back('{K_RES, 32'h14, 1'b0});
        sb.push_back('{K_REQ, 32'h18, 1'b0});
        req_val = 1'b1; req_pc = 32'h18; resolve_val = 1'b1; resolve_taken = 1'b0;
        @(negedge clk);
        chk("prio_c1_req_rdy", {31'd0, req_rdy}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("prio_c2_req_rdy", {31'd0, req_rdy}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("prio_c3_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("prio_c3_no_update", {31'd0, bp_update_en}, 32'd0);
        @(posedge clk); #1;
        req_val = 1'b0; resolve_val = 1'b0;
        do_resolve(1'b0, 32'h18, 1'b0);
        check_counters("prio", 8, 1);

        // Training from a fresh reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        do_req(32'h200, 1'b0);
        do_resolve(1'b1, 32'h200, 1'b1);
        do_req(32'h200, 1'b1);
        do_resolve(1'b1, 32'h200, 1'b0);
        do_req(32'h200, 1'b1);
        do_resolve(1'b1, 32'h200, 1'b0);
        check_counters("train", 3, 1);

        // Reset with three entries in flight
        do_req(32'h300, 1'b0);
        do_req(32'h304, 1'b0);
        do_req(32'h308, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_rdy", {31'd0, req_rdy}, 32'd0);
        chk("midrst_resolve_rdy", {31'd0, resolve_rdy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        resolve_val = 1'b1; resolve_taken = 1'b1;
        @(negedge clk);
        chk("midrst_resolve_rdy_after", {31'd0, resolve_rdy}, 32'd0);
        chk("midrst_no_update", {31'd0, bp_update_en}, 32'd0);
        chk("midrst_num_branches", num_branches, 32'd0);
        chk("midrst_num_mispredicts", num_mispredicts, 32'd0);
        @(posedge clk); #1;
        resolve_val = 1'b0;
        @(negedge clk);
        chk("midrst_no_mispredict", {31'd0, mispredict}, 32'd0);
        chk("scoreboard_drained", sb.size(), 32'd0);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
